// File: rtl/aes_pkg.sv
// Shared constants for the AES-128 key schedule: widths, round constants and
// controller state encodings.
package aes_pkg;

    localparam int KEY_W = 128;
    localparam int NR    = 10;
    localparam int IDX_W = 4;

    // Byte i-1 holds Rcon for round i (round 1 in the least significant byte).
    localparam logic [79:0] RCON_TABLE = 80'h36_1b_80_40_20_10_08_04_02_01;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GEN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    function automatic logic [7:0] rcon_of(input logic [IDX_W-1:0] rnd);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 1; i <= NR; i++) begin
            r = (rnd == IDX_W'(i)) ? RCON_TABLE[(i-1)*8 +: 8] : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/Key_Generation.sv
// Combinational single-round AES-128 key expansion: derives round key rnd_i
// from the previous round key.
module Key_Generation
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    input  logic [IDX_W-1:0] rnd_i,
    output logic [KEY_W-1:0] key_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = b[i] ? (p ^ aa) : p;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] rot_s, rc_s;
    logic [31:0] n0_s, n1_s, n2_s, n3_s;

    // RotWord/SubWord/Rcon stage followed by the word XOR chain.
    always_comb begin
        w0_s  = key_i[127:96];
        w1_s  = key_i[95:64];
        w2_s  = key_i[63:32];
        w3_s  = key_i[31:0];
        rot_s = {w3_s[23:0], w3_s[31:24]};
        rc_s  = {sbox(rot_s[31:24]) ^ rcon_of(rnd_i), sbox(rot_s[23:16]),
                 sbox(rot_s[15:8]), sbox(rot_s[7:0])};
        n0_s  = rc_s ^ w0_s;
        n1_s  = n0_s ^ w1_s;
        n2_s  = n1_s ^ w2_s;
        n3_s  = n2_s ^ w3_s;
        key_o = {n0_s, n1_s, n2_s, n3_s};
    end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller: generates round keys 1..10 one per clock
// into an 11-entry bank and serves them through a registered read port.
module key_schedule_ctrl
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_key
);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] rnd_q, rnd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic [KEY_W-1:0] bank_q [0:NR];
    logic [KEY_W-1:0] rd_key_q;

    logic             wr_en_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [KEY_W-1:0] wr_data_s;
    logic [KEY_W-1:0] prev_key_s;
    logic [KEY_W-1:0] round_key_s;
    logic [KEY_W-1:0] rd_data_s;

    // Select bank[rnd-1] as the round block input.
    always_comb begin
        prev_key_s = '0;
        for (int i = 0; i < NR; i++) begin
            prev_key_s = (rnd_q == IDX_W'(i + 1)) ? bank_q[i] : prev_key_s;
        end
    end

    Key_Generation u_keygen (
        .key_i (prev_key_s),
        .rnd_i (rnd_q),
        .key_o (round_key_s)
    );

    // Read mux; indices beyond round 10 resolve to zero.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i <= NR; i++) begin
            rd_data_s = (rd_idx == IDX_W'(i)) ? bank_q[i] : rd_data_s;
        end
    end

    // FSM next state, round counter and bank write request.
    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        wr_en_s   = 1'b0;
        wr_idx_s  = '0;
        wr_data_s = '0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (start) begin
                    wr_en_s   = 1'b1;
                    wr_idx_s  = '0;
                    wr_data_s = key_in;
                    rnd_d     = IDX_W'(1);
                    valid_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_GEN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_GEN: begin
                wr_en_s   = 1'b1;
                wr_idx_s  = rnd_q;
                wr_data_s = round_key_s;
                if (rnd_q == IDX_W'(NR)) begin
                    state_d = ST_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    rnd_d   = rnd_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, status flags, bank and read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rnd_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            rd_key_q <= '0;
            for (int i = 0; i <= NR; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            rd_key_q <= rd_data_s;
            for (int i = 0; i <= NR; i++) begin
                if (wr_en_s && (wr_idx_s == IDX_W'(i))) begin
                    bank_q[i] <= wr_data_s;
                end
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = valid_q;
    assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl against a word-level FIPS-197
// key expansion model.
module tb_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] mk [0:10];
    logic [7:0]   sb [0:255];

    key_schedule_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box via exp/log tables over generator 3, then the affine transform.
    task automatic build_sbox();
        logic [7:0] ex [0:255];
        logic [7:0] lg [0:255];
        logic [7:0] inv;
        ex[0] = 8'h01;
        for (int i = 1; i < 256; i++) ex[i] = ex[i-1] ^ xt(ex[i-1]);
        for (int i = 0; i < 256; i++) lg[i] = 8'h00;
        for (int i = 0; i < 255; i++) lg[ex[i]] = 8'(i);
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : ex[(255 - int'(lg[x])) % 255];
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic model_clear();
        for (int r = 0; r < 11; r++) mk[r] = '0;
    endtask

    function automatic logic [127:0] exp_rd(input int idx);
        return (idx <= 10) ? mk[idx] : 128'h0;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic read_key(input int idx, output logic [127:0] k);
        rd_idx = 4'(idx);
        step();
        k = rd_key;
    endtask

    task automatic check_bank(input string tag);
        logic [127:0] k;
        for (int i = 0; i < 11; i++) begin
            read_key(i, k);
            chk($sformatf("%s_r%0d", tag, i), k, mk[i]);
        end
    endtask

    // Accepts a key and waits for done; lat counts edges after the accepting edge.
    task automatic expand_and_wait(input logic [127:0] key, output int lat);
        start  = 1'b1;
        key_in = key;
        step();
        start  = 1'b0;
        chk("busy_after_start", 128'(busy), 128'd1);
        lat = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        chk("done_latency", 128'(lat), 128'd10);
        chk("valid_at_done", 128'(keys_valid), 128'd1);
        chk("busy_at_done", 128'(busy), 128'd0);
    endtask

    initial begin
        logic [127:0] k, ka, kb;
        int lat, cyc, done_cnt, done_at, idx;

        rst = 1'b1; start = 1'b0; key_in = '0; rd_idx = '0;
        build_sbox();
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_valid", 128'(keys_valid), 128'd0);
        chk("rst_rdkey", rd_key, 128'd0);
        model_clear();
        check_bank("rst_bank");

        // FIPS-197 Appendix A vector
        ka = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        model_expand(ka);
        expand_and_wait(ka, lat);
        step();
        chk("fips_done_one_cycle", 128'(done), 128'd0);
        read_key(0, k);  chk("fips_r0", k, ka);
        read_key(1, k);  chk("fips_r1", k, 128'ha0fafe1788542cb123a339392a6c7605);
        read_key(10, k); chk("fips_r10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_bank("fips");

        model_expand(128'h0);
        expand_and_wait(128'h0, lat);
        step();
        read_key(1, k);  chk("zero_r1", k, 128'h62636363626363636263636362636363);
        read_key(10, k); chk("zero_r10", k, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        for (int n = 0; n < 3; n++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            model_expand(ka);
            expand_and_wait(ka, lat);
            step();
            check_bank($sformatf("rand%0d", n));
        end

        // start during GEN must be ignored
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = ~ka;
        start = 1'b1; key_in = ka;
        step();
        start = 1'b0;
        cyc = 0; done_cnt = 0; done_at = -1;
        repeat (3) begin
            step(); cyc++;
            if (done) begin done_cnt++; done_at = cyc; end
        end
        start = 1'b1; key_in = kb;
        step(); cyc++;
        start = 1'b0; key_in = '0;
        chk("gen_start_busy", 128'(busy), 128'd1);
        if (done) begin done_cnt++; done_at = cyc; end
        while (cyc < 30) begin
            step(); cyc++;
            if (done) begin done_cnt++; done_at = cyc; end
        end
        chk("gen_start_done_count", 128'(done_cnt), 128'd1);
        chk("gen_start_done_at", 128'(done_at), 128'd10);
        model_expand(ka);
        check_bank("gen_start");

        // back-to-back start in the FIN cycle
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        expand_and_wait(ka, lat);
        start = 1'b1; key_in = kb;
        step();
        start = 1'b0;
        chk("b2b_valid_drop", 128'(keys_valid), 128'd0);
        chk("b2b_done_drop", 128'(done), 128'd0);
        chk("b2b_busy", 128'(busy), 128'd1);
        lat = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        chk("b2b_done_latency", 128'(lat), 128'd10);
        step();
        model_expand(kb);
        check_bank("b2b");

        // reset in the middle of GEN
        start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
        step();
        start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_valid", 128'(keys_valid), 128'd0);
        chk("midrst_done", 128'(done), 128'd0);
        done_cnt = 0;
        repeat (15) begin
            step();
            if (done) done_cnt++;
        end
        chk("midrst_no_done", 128'(done_cnt), 128'd0);
        model_clear();
        check_bank("midrst");

        // read boundary and streaming reads
        ka = {$urandom, $urandom, $urandom, $urandom};
        model_expand(ka);
        expand_and_wait(ka, lat);
        step();
        read_key(11, k); chk("rd_idx11", k, 128'h0);
        read_key(15, k); chk("rd_idx15", k, 128'h0);
        for (int n = 0; n < 20; n++) begin
            idx = int'($urandom_range(0, 15));
            rd_idx = 4'(idx);
            step();
            chk($sformatf("stream_%0d_idx%0d", n, idx), rd_key, exp_rd(idx));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
